// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter controller: steps an external 1-bit shift unit
// (shamt 00 = pass, 01 = right 1, 10 = left 1) `amount` times and holds the result.
// Ports: clk, rst_n (async, active-low), start/dir/amount/data_in request,
// clear (sync abort), su_dataa/su_shamt/su_dataout shift-unit link,
// busy/done status, data_out held result.
module shift_sequencer #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          dir,
  input  logic [AW-1:0] amount,
  input  logic [N-1:0]  data_in,
  input  logic          clear,
  output logic [N-1:0]  su_dataa,
  output logic [1:0]    su_shamt,
  input  logic [N-1:0]  su_dataout,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  data_out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  acc;
  logic [AW-1:0] cnt;
  logic          dir_r;
  logic          accept;
  logic          last_step;

  assign accept    = (state == IDLE) || (state == DONE);
  assign last_step = (cnt == AW'(1));

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) state_next = (amount != '0) ? SHIFT : DONE;
          else       state_next = IDLE;
        end
        SHIFT: begin
          if (last_step) state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      dir_r    <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_next;
      if (clear) begin
        cnt <= '0;
      end else if (accept && start) begin
        acc   <= data_in;
        dir_r <= dir;
        cnt   <= amount;
        if (amount == '0) data_out <= data_in;
      end else if (state == SHIFT) begin
        acc <= su_dataout;
        cnt <= cnt - AW'(1);
        if (last_step) data_out <= su_dataout;
      end
    end
  end

  always_comb begin
    su_shamt = 2'b00;
    if (state == SHIFT) su_shamt = dir_r ? 2'b10 : 2'b01;
  end

  assign su_dataa = acc;
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          dir;
  logic [AW-1:0] amount;
  logic [N-1:0]  data_in;
  logic          clear;
  logic [N-1:0]  su_dataa;
  logic [1:0]    su_shamt;
  logic [N-1:0]  su_dataout;
  logic          busy;
  logic          done;
  logic [N-1:0]  data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .amount(amount),
    .data_in(data_in), .clear(clear), .su_dataa(su_dataa), .su_shamt(su_shamt),
    .su_dataout(su_dataout), .busy(busy), .done(done), .data_out(data_out)
  );

  always_comb begin
    case (su_shamt)
      2'b01:   su_dataout = su_dataa >> 1;
      2'b10:   su_dataout = su_dataa << 1;
      default: su_dataout = su_dataa;
    endcase
  end

  typedef struct {
    logic [7:0] d;
    logic       dr;
    logic [2:0] a;
    logic [7:0] res;
    int         busy_n;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] ref_shift(logic [7:0] d, logic dr, logic [2:0] a);
    return dr ? (d << a) : (d >> a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [7:0] d, input logic dr, input logic [2:0] a);
    start   = 1'b1;
    data_in = d;
    dir     = dr;
    amount  = a;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] code, input logic [7:0] prev,
                           output int busy_n, output int done_at,
                           output bit shamt_ok, output bit stable_ok);
    busy_n = 0; done_at = -1; shamt_ok = 1'b1; stable_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_n++;
        if (su_shamt !== code) shamt_ok = 1'b0;
      end else if (su_shamt !== 2'b00) begin
        shamt_ok = 1'b0;
      end
      if (done) begin
        done_at = i;
        return;
      end
      if (data_out !== prev) stable_ok = 1'b0;
    end
  endtask

  task automatic run_checked(input string tag, input logic [7:0] d, input logic dr,
                             input logic [2:0] a, input logic [7:0] exp_res, input int exp_busy);
    int  bn, da;
    bit  sok, stok;
    logic [7:0] prev;
    prev = data_out;
    launch(d, dr, a);
    wait_done(dr ? 2'b10 : 2'b01, prev, bn, da, sok, stok);
    check({tag, "_result"}, 32'(data_out), 32'(exp_res));
    check({tag, "_busy_cycles"}, 32'(bn), 32'(exp_busy));
    check({tag, "_done_at"}, 32'(da), 32'(exp_busy + 1));
    check({tag, "_shamt"}, 32'(sok), 32'd1);
    check({tag, "_dout_stable"}, 32'(stok), 32'd1);
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] rd;
    logic       rdir;
    logic [2:0] ra;

    vecs[0] = '{8'hB4, 1'b1, 3'd3, 8'hA0, 3};
    vecs[1] = '{8'hB4, 1'b0, 3'd2, 8'h2D, 2};
    vecs[2] = '{8'hFF, 1'b1, 3'd7, 8'h80, 7};
    vecs[3] = '{8'h5A, 1'b0, 3'd0, 8'h5A, 0};
    vecs[4] = '{8'h01, 1'b1, 3'd7, 8'h80, 7};
    vecs[5] = '{8'h80, 1'b0, 3'd7, 8'h01, 7};
    vecs[6] = '{8'h81, 1'b1, 3'd1, 8'h02, 1};
    vecs[7] = '{8'hC3, 1'b0, 3'd1, 8'h61, 1};

    // reset with start held
    rst_n = 1'b0; start = 1'b1; clear = 1'b0;
    data_in = 8'hAA; dir = 1'b1; amount = 3'd3;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_su_dataa", 32'(su_dataa), 0);
    check("rst_su_shamt", 32'(su_shamt), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_busy", 32'(busy), 0);
    check("post_rst_idle_done", 32'(done), 0);

    // table vectors, each launched in the DONE cycle of the previous one
    for (int i = 0; i < 8; i++)
      run_checked($sformatf("vec%0d", i), vecs[i].d, vecs[i].dr, vecs[i].a,
                  vecs[i].res, vecs[i].busy_n);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 0);
    check("idle_after_done_busy", 32'(busy), 0);

    // clear mid-shift, with a start ignored during SHIFT and one colliding with clear
    prev = data_out;
    launch(8'hFF, 1'b0, 3'd5);
    @(negedge clk);
    check("clr_busy1", 32'(busy), 1);
    start = 1'b1; data_in = 8'h00; dir = 1'b1; amount = 3'd1;
    @(negedge clk);
    check("clr_start_ignored_busy", 32'(busy), 1);
    check("clr_start_ignored_acc", 32'(su_dataa), 32'h7F);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; start = 1'b0;
    @(negedge clk);
    check("clr_busy", 32'(busy), 0);
    check("clr_done", 32'(done), 0);
    check("clr_data_out_held", 32'(data_out), 32'(prev));
    check("clr_acc_held", 32'(su_dataa), 32'h7F);
    begin
      bit saw_done = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      check("clr_no_done", 32'(saw_done), 0);
    end
    run_checked("after_clr", 8'h3C, 1'b1, 3'd2, 8'hF0, 2);

    // async reset mid-shift
    @(negedge clk);
    launch(8'hFF, 1'b1, 3'd7);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_data_out", 32'(data_out), 0);
    check("arst_su_dataa", 32'(su_dataa), 0);
    check("arst_su_shamt", 32'(su_shamt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_checked("after_arst", 8'hB4, 1'b1, 3'd3, 8'hA0, 3);

    // randomized ops against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
      rd   = 8'($urandom);
      rdir = 1'($urandom);
      ra   = 3'($urandom_range(0, 7));
      run_checked($sformatf("rnd%0d", i), rd, rdir, ra, ref_shift(rd, rdir, ra), int'(ra));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
